// File: rtl/cnn_ctrl_pkg.sv
// cnn_ctrl_pkg
// Shared definitions for the CNN sequencer: state encoding, default task
// geometry, and index widths derived from that geometry.
package cnn_ctrl_pkg;

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Default task geometry
  localparam int DEF_IN_LEN   = 72;  // input beats per task
  localparam int DEF_OUT_W    = 6;   // conv output width/height
  localparam int DEF_PIPE_LAT = 4;   // conv engine pipeline depth
  localparam int DEF_FC_STEPS = 8;   // FC accumulation cycles (task 0)
  localparam int DEF_OUT_LEN0 = 3;   // output beats, task 0
  localparam int DEF_OUT_LEN1 = 1;   // output beats, task 1

  // Index widths seen on the ports
  localparam int LOAD_IDX_W = $clog2(DEF_IN_LEN);
  localparam int WIN_IDX_W  = $clog2(DEF_OUT_W);
  localparam int FC_IDX_W   = $clog2(DEF_FC_STEPS);
  localparam int OUT_IDX_W  = $clog2(imax(DEF_OUT_LEN0, DEF_OUT_LEN1));

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_CONV,
    ST_DRAIN,
    ST_FC,
    ST_OUT
  } state_e;

endpackage

// File: rtl/cnn_win_gen.sv
// cnn_win_gen
// Row-major window counter for the conv engine. Advances one window per
// valid/ready handshake and holds its position while the engine stalls.
// Ports:
//   clk, rst_n   clock, synchronous active-low reset
//   clr_i        force position back to (0,0)
//   en_i         window request is currently being offered
//   ready_i      engine accepts the offered window
//   row_o/col_o  current window position
//   last_o       current window is the final one (OUT_W-1, OUT_W-1)
//   fire_o       handshake happens this cycle
module cnn_win_gen #(
  parameter int OUT_W = 6,
  parameter int IDX_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic             ready_i,
  output logic [IDX_W-1:0] row_o,
  output logic [IDX_W-1:0] col_o,
  output logic             last_o,
  output logic             fire_o
);

  logic [IDX_W-1:0] row_q, row_d;
  logic [IDX_W-1:0] col_q, col_d;

  assign fire_o = en_i && ready_i;
  assign last_o = (row_q == IDX_W'(OUT_W - 1)) && (col_q == IDX_W'(OUT_W - 1));
  assign row_o  = row_q;
  assign col_o  = col_q;

  always_comb begin
    row_d = row_q;
    col_d = col_q;
    if (clr_i) begin
      row_d = '0;
      col_d = '0;
    end else if (fire_o) begin
      if (col_q == IDX_W'(OUT_W - 1)) begin
        col_d = '0;
        // The final handshake returns to (0,0) so the indices read 0 once
        // the window phase is over.
        row_d = last_o ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      row_q <= '0;
      col_q <= '0;
    end else begin
      row_q <= row_d;
      col_q <= col_d;
    end
  end

endmodule

// File: rtl/cnn_seq_ctrl.sv
// cnn_seq_ctrl
// Central sequencer for the CNN datapath. Accepts the input burst, steps the
// conv engine window by window, waits out the engine pipeline, runs the FC
// stage (task 0 only) and frames the output burst. Carries no data.
// Ports:
//   clk, rst_n              clock, synchronous active-low reset
//   in_valid                input beat valid
//   task_number, mode       task/mode select, captured on the first beat
//   eng_ready               conv engine accepts a window
//   load_en, load_idx       store strobe and beat index for the input buffer
//   win_valid, win_row/col  conv window request and position
//   fc_valid, fc_idx        FC step strobe and index
//   task_q, mode_q          captured task/mode
//   busy                    sequencer is not idle
//   proto_err               in_valid seen while a task is being processed
//   out_valid, out_idx      output beat framing
// All outputs are registered.
module cnn_seq_ctrl
  import cnn_ctrl_pkg::*;
#(
  parameter int IN_LEN   = DEF_IN_LEN,
  parameter int OUT_W    = DEF_OUT_W,
  parameter int PIPE_LAT = DEF_PIPE_LAT,
  parameter int FC_STEPS = DEF_FC_STEPS,
  parameter int OUT_LEN0 = DEF_OUT_LEN0,
  parameter int OUT_LEN1 = DEF_OUT_LEN1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  input  logic                  task_number,
  input  logic [1:0]            mode,
  input  logic                  eng_ready,
  output logic                  load_en,
  output logic [LOAD_IDX_W-1:0] load_idx,
  output logic                  win_valid,
  output logic [WIN_IDX_W-1:0]  win_row,
  output logic [WIN_IDX_W-1:0]  win_col,
  output logic                  fc_valid,
  output logic [FC_IDX_W-1:0]   fc_idx,
  output logic                  task_q,
  output logic [1:0]            mode_q,
  output logic                  busy,
  output logic                  proto_err,
  output logic                  out_valid,
  output logic [OUT_IDX_W-1:0]  out_idx
);

  // One shared phase counter, wide enough for the longest phase.
  localparam int CNT_W = $clog2(imax(imax(IN_LEN, PIPE_LAT),
                                     imax(FC_STEPS, imax(OUT_LEN0, OUT_LEN1))));

  state_e state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic                  task_lat_q, task_lat_d;
  logic [1:0]            mode_lat_q, mode_lat_d;
  logic                  load_en_q, load_en_d;
  logic [LOAD_IDX_W-1:0] load_idx_q, load_idx_d;
  logic                  win_valid_q, win_valid_d;
  logic                  fc_valid_q, fc_valid_d;
  logic [FC_IDX_W-1:0]   fc_idx_q, fc_idx_d;
  logic                  busy_q, busy_d;
  logic                  proto_err_q, proto_err_d;
  logic                  out_valid_q, out_valid_d;
  logic [OUT_IDX_W-1:0]  out_idx_q, out_idx_d;

  logic             win_last, win_fire;
  logic [CNT_W-1:0] out_last_cnt;

  cnn_win_gen #(
    .OUT_W (OUT_W),
    .IDX_W (WIN_IDX_W)
  ) u_win_gen (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr_i   (state_q != ST_CONV),
    .en_i    (state_q == ST_CONV),
    .ready_i (eng_ready),
    .row_o   (win_row),
    .col_o   (win_col),
    .last_o  (win_last),
    .fire_o  (win_fire)
  );

  assign out_last_cnt = task_lat_q ? CNT_W'(OUT_LEN1 - 1) : CNT_W'(OUT_LEN0 - 1);

  // Next state and counter
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    task_lat_d = task_lat_q;
    mode_lat_d = mode_lat_q;
    load_en_d  = 1'b0;
    load_idx_d = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          task_lat_d = task_number;
          mode_lat_d = mode;
          load_en_d  = 1'b1;
          if (IN_LEN == 1) begin
            state_d = ST_CONV;
            cnt_d   = '0;
          end else begin
            state_d = ST_LOAD;
            cnt_d   = CNT_W'(1);
          end
        end
      end
      ST_LOAD: begin
        // Gap cycles (in_valid low) simply wait; they never abort a burst.
        if (in_valid) begin
          load_en_d  = 1'b1;
          load_idx_d = LOAD_IDX_W'(cnt_q);
          if (cnt_q == CNT_W'(IN_LEN - 1)) begin
            state_d = ST_CONV;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      ST_CONV: begin
        if (win_fire && win_last) begin
          state_d = ST_DRAIN;
          cnt_d   = '0;
        end
      end
      ST_DRAIN: begin
        if (cnt_q == CNT_W'(PIPE_LAT - 1)) begin
          state_d = task_lat_q ? ST_OUT : ST_FC;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_FC: begin
        if (cnt_q == CNT_W'(FC_STEPS - 1)) begin
          state_d = ST_OUT;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_OUT: begin
        if (cnt_q == out_last_cnt) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Output registers are loaded from the upcoming state so each strobe lines
  // up with the cycle its state is occupied.
  always_comb begin
    win_valid_d = (state_d == ST_CONV);
    fc_valid_d  = (state_d == ST_FC);
    fc_idx_d    = (state_d == ST_FC) ? FC_IDX_W'(cnt_d) : '0;
    out_valid_d = (state_d == ST_OUT);
    out_idx_d   = (state_d == ST_OUT) ? OUT_IDX_W'(cnt_d) : '0;
    busy_d      = (state_d != ST_IDLE);
    proto_err_d = in_valid && (state_q != ST_IDLE) && (state_q != ST_LOAD);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      task_lat_q  <= 1'b0;
      mode_lat_q  <= '0;
      load_en_q   <= 1'b0;
      load_idx_q  <= '0;
      win_valid_q <= 1'b0;
      fc_valid_q  <= 1'b0;
      fc_idx_q    <= '0;
      busy_q      <= 1'b0;
      proto_err_q <= 1'b0;
      out_valid_q <= 1'b0;
      out_idx_q   <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      task_lat_q  <= task_lat_d;
      mode_lat_q  <= mode_lat_d;
      load_en_q   <= load_en_d;
      load_idx_q  <= load_idx_d;
      win_valid_q <= win_valid_d;
      fc_valid_q  <= fc_valid_d;
      fc_idx_q    <= fc_idx_d;
      busy_q      <= busy_d;
      proto_err_q <= proto_err_d;
      out_valid_q <= out_valid_d;
      out_idx_q   <= out_idx_d;
    end
  end

  assign load_en   = load_en_q;
  assign load_idx  = load_idx_q;
  assign win_valid = win_valid_q;
  assign fc_valid  = fc_valid_q;
  assign fc_idx    = fc_idx_q;
  assign task_q    = task_lat_q;
  assign mode_q    = mode_lat_q;
  assign busy      = busy_q;
  assign proto_err = proto_err_q;
  assign out_valid = out_valid_q;
  assign out_idx   = out_idx_q;

endmodule

// File: tb/tb_cnn_seq_ctrl.sv
// tb_cnn_seq_ctrl
// Drives whole tasks through the sequencer and compares every output on
// every cycle against a timeline model: beats accepted so far, windows
// handed over so far, and the offset from the final window handshake.
module tb_cnn_seq_ctrl;

  localparam int N_BEATS = 72;
  localparam int N_WIN   = 36;
  localparam int SIDE    = 6;
  localparam int DRAIN_C = 4;
  localparam int FC_C    = 8;
  localparam int OUT0_C  = 3;
  localparam int OUT1_C  = 1;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       task_number = 1'b0;
  logic [1:0] mode = 2'd0;
  logic       eng_ready = 1'b0;
  logic       load_en;
  logic [6:0] load_idx;
  logic       win_valid;
  logic [2:0] win_row;
  logic [2:0] win_col;
  logic       fc_valid;
  logic [2:0] fc_idx;
  logic       task_q;
  logic [1:0] mode_q;
  logic       busy;
  logic       proto_err;
  logic       out_valid;
  logic [1:0] out_idx;

  int checks = 0;
  int failures = 0;
  logic       exp_tq = 1'b0;
  logic [1:0] exp_mq = 2'd0;

  always #5 clk = ~clk;

  cnn_seq_ctrl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .task_number (task_number),
    .mode        (mode),
    .eng_ready   (eng_ready),
    .load_en     (load_en),
    .load_idx    (load_idx),
    .win_valid   (win_valid),
    .win_row     (win_row),
    .win_col     (win_col),
    .fc_valid    (fc_valid),
    .fc_idx      (fc_idx),
    .task_q      (task_q),
    .mode_q      (mode_q),
    .busy        (busy),
    .proto_err   (proto_err),
    .out_valid   (out_valid),
    .out_idx     (out_idx)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d t=%0t", tag, obs, exp_v, $time);
    end
  endtask

  task automatic check_outs(input string ph, input logic le, input int li,
                            input logic wv, input int wr, input int wc,
                            input logic fv, input int fi, input logic ov, input int oi,
                            input logic bz, input logic pe);
    chk({ph, ".load_en"},   32'(load_en),   32'(le));
    chk({ph, ".load_idx"},  32'(load_idx),  32'(li));
    chk({ph, ".win_valid"}, 32'(win_valid), 32'(wv));
    chk({ph, ".win_row"},   32'(win_row),   32'(wr));
    chk({ph, ".win_col"},   32'(win_col),   32'(wc));
    chk({ph, ".fc_valid"},  32'(fc_valid),  32'(fv));
    chk({ph, ".fc_idx"},    32'(fc_idx),    32'(fi));
    chk({ph, ".out_valid"}, 32'(out_valid), 32'(ov));
    chk({ph, ".out_idx"},   32'(out_idx),   32'(oi));
    chk({ph, ".busy"},      32'(busy),      32'(bz));
    chk({ph, ".proto_err"}, 32'(proto_err), 32'(pe));
    chk({ph, ".task_q"},    32'(task_q),    32'(exp_tq));
    chk({ph, ".mode_q"},    32'(mode_q),    32'(exp_mq));
  endtask

  task automatic check_zero(input string ph);
    exp_tq = 1'b0;
    exp_mq = 2'd0;
    check_outs(ph, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // One complete task.
  //   gap_mode   0 contiguous, 1 gaps at burst cycles 10-12 and 40, 2 random gaps
  //   stall_w    window number held back stall_n cycles (-1 none)
  //   proto_mode 0 none, 1 random stray beats, 2 stray beat in DRAIN and last OUT cycle
  //   rst_w      window number at which reset is applied (-1 none)
  task automatic run_task(input int tsk, input int md, input int gap_mode,
                          input int stall_w, input int stall_n, input bit rand_ready,
                          input int proto_mode, input int rst_w, output int conv_len);
    int acc, w, e_edge, t_edge, pos, k, d, last_d, stall_left;
    bit iv, er, rn;
    logic tn;
    logic [1:0] mv;
    logic le, wv, fv, ov, bz, pe;
    int li, wr, wc, fi, oi;
    acc = 0; w = 0; e_edge = -1; t_edge = -1; pos = 0; k = 0;
    stall_left = stall_n; conv_len = -1;
    // offset (from the final handshake) of the last out_valid cycle
    last_d = (tsk == 0) ? DRAIN_C + FC_C + OUT0_C - 1 : DRAIN_C + OUT1_C - 1;
    forever begin
      if (k > 3000) begin
        chk("run_cycle_budget", 32'(k), 32'd0);
        in_valid = 1'b0;
        return;
      end
      iv = 1'b0; er = 1'b1; rn = 1'b1;
      tn = 1'($urandom); mv = 2'($urandom);
      if (acc < N_BEATS) begin
        if (acc == 0) begin
          iv = 1'b1; tn = 1'(tsk); mv = 2'(md);
        end else if (gap_mode == 1) begin
          iv = !(pos inside {10, 11, 12, 40});
          if (!iv) tn = (tsk == 0);
        end else if (gap_mode == 2) begin
          iv = ($urandom_range(0, 3) != 0);
        end else begin
          iv = 1'b1;
        end
      end else begin
        d = (e_edge >= 0) ? k - e_edge : -1;
        if (proto_mode == 1) iv = ($urandom_range(0, 4) == 0);
        else if (proto_mode == 2 && e_edge >= 0 && (d == 1 || d == last_d + 1)) iv = 1'b1;
        if (w < N_WIN) begin
          if (w == stall_w && stall_left > 0) begin
            er = 1'b0;
            stall_left--;
          end else if (rand_ready) begin
            er = ($urandom_range(0, 2) != 0);
          end
          if (rst_w >= 0 && w == rst_w) rn = 1'b0;
        end
      end
      in_valid = iv; task_number = tn; mode = mv; eng_ready = er; rst_n = rn;
      @(posedge clk);
      #1;
      if (!rn) begin
        rst_n = 1'b1;
        in_valid = 1'b0;
        check_zero("mid_reset");
        $display("task=%0d mode=%0d aborted by reset at window %0d", tsk, md, w);
        return;
      end
      le = 1'b0; li = 0; pe = 1'b0;
      if (acc < N_BEATS) begin
        if (iv) begin
          if (acc == 0) begin exp_tq = tn; exp_mq = mv; end
          le = 1'b1; li = acc; acc++;
          if (acc == N_BEATS) t_edge = k;
        end
        pos++;
      end else begin
        pe = iv;
        if (w < N_WIN && er) begin
          w++;
          if (w == N_WIN) begin e_edge = k; conv_len = k - t_edge; end
        end
      end
      wv = (acc == N_BEATS) && (w < N_WIN);
      wr = wv ? w / SIDE : 0;
      wc = wv ? w % SIDE : 0;
      d  = (e_edge >= 0) ? k - e_edge : -1;
      fv = (tsk == 0) && d >= DRAIN_C && d < DRAIN_C + FC_C;
      fi = fv ? d - DRAIN_C : 0;
      if (tsk == 0) ov = d >= DRAIN_C + FC_C && d <= last_d;
      else          ov = d >= DRAIN_C && d <= last_d;
      oi = ov ? d - (last_d - ((tsk == 0) ? OUT0_C : OUT1_C) + 1) : 0;
      bz = !(e_edge >= 0 && d > last_d);
      check_outs("cyc", le, li, wv, wr, wc, fv, fi, ov, oi, bz, pe);
      if (e_edge >= 0 && d == last_d + 1) begin
        in_valid = 1'b0;
        $display("task=%0d mode=%0d gaps=%0d stall_w=%0d proto=%0d load_end=%0d conv_len=%0d",
                 tsk, md, gap_mode, stall_w, proto_mode, t_edge, conv_len);
        return;
      end
      k++;
    end
  endtask

  initial begin
    int cl;
    // Reset state
    rst_n = 1'b0; in_valid = 1'b0; eng_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_zero("reset");
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_zero("idle");

    // Nominal task 0, mode 2
    run_task(0, 2, 0, -1, 0, 1'b0, 0, -1, cl);
    chk("nominal_conv_len", 32'(cl), 32'd36);
    // Task 1
    run_task(1, 2, 0, -1, 0, 1'b0, 0, -1, cl);
    chk("task1_conv_len", 32'(cl), 32'd36);
    // Input gaps with task_number flipping during gaps
    run_task(0, 1, 1, -1, 0, 1'b0, 0, -1, cl);
    run_task(1, 3, 1, -1, 0, 1'b0, 0, -1, cl);
    // Backpressure: 3 stall cycles on window (2,5)
    run_task(0, 3, 0, 17, 3, 1'b0, 0, -1, cl);
    chk("stall_conv_len", 32'(cl), 32'd39);
    // Stray beats in DRAIN and on the last OUT cycle
    run_task(0, 2, 0, -1, 0, 1'b0, 2, -1, cl);
    run_task(1, 1, 0, -1, 0, 1'b0, 2, -1, cl);
    // Reset mid-CONV at window (1,3), then a fresh burst
    run_task(0, 2, 0, -1, 0, 1'b0, 0, 9, cl);
    run_task(0, 2, 0, -1, 0, 1'b0, 0, -1, cl);
    chk("post_reset_conv_len", 32'(cl), 32'd36);
    // Randomised tasks
    for (int i = 0; i < 4; i++) begin
      run_task(int'($urandom_range(0, 1)), int'($urandom_range(0, 3)), 2, -1, 0,
               1'b1, 1, -1, cl);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
